gearbox_pack: RTL and testbench

GEARBOX_PACK -- requirements
Module: gearbox_pack

---
 rtl/gearbox_pack.sv | 87 ++++++++
 tb/tb_gearbox_pack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_pack.sv
// Width gearbox: packs IN_W-bit input words into OUT_W-bit output symbols, LSB first.
// Frames end with in_last; the tail is flushed as a zero-padded symbol carrying out_last.
module gearbox_pack #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [IN_W-1:0]                       in_data,
   input  logic                                  in_valid,
   input  logic                                  in_last,
   output logic                                  in_ready,
   output logic [OUT_W-1:0]                      out_data,
   output logic                                  out_valid,
   output logic                                  out_last,
   input  logic                                  out_ready,
   output logic [$clog2(IN_W+OUT_W+1)-1:0]       level
);

   localparam int CAP   = IN_W + OUT_W;
   localparam int CNT_W = $clog2(CAP + 1);

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [CAP-1:0]   buffer_q, buffer_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [0:0]       state_q, state_d;

   logic             acc, pop;
   int               lvl, lvl_n;
   logic [CNT_W-1:0] pos;
   logic [CAP-1:0]   in_ext;

   assign level = level_q;

   // Bits above level are kept zero, so the drain padding and the OR-append come for free.
   always_comb begin
      lvl       = int'(level_q);
      in_ready  = (state_q == FILL) && (lvl + IN_W <= CAP);
      out_valid = (state_q == FILL) ? (lvl >= OUT_W) : (lvl > 0);
      out_last  = (state_q == DRAIN) && (lvl > 0) && (lvl <= OUT_W);
      out_data  = buffer_q[OUT_W-1:0];
      acc       = in_valid && in_ready;
      pop       = out_valid && out_ready;
      in_ext    = {{OUT_W{1'b0}}, in_data};
   end

   always_comb begin
      buffer_d = buffer_q;
      state_d  = state_q;
      lvl_n    = lvl;
      pos      = '0;
      if (pop) begin
         if (state_q == DRAIN && lvl <= OUT_W) begin
            buffer_d = '0;
            lvl_n    = 0;
            state_d  = FILL;
         end else begin
            buffer_d = buffer_q >> OUT_W;
            lvl_n    = lvl - OUT_W;
         end
      end
      if (acc) begin
         pos      = CNT_W'(lvl_n);
         buffer_d = buffer_d | (in_ext << pos);
         lvl_n    = lvl_n + IN_W;
         if (in_last) begin
            state_d = DRAIN;
         end
      end
      level_d = CNT_W'(lvl_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer_q <= '0;
         level_q  <= '0;
         state_q  <= FILL;
      end else begin
         buffer_q <= buffer_d;
         level_q  <= level_d;
         state_q  <= state_d;
      end
   end

endmodule

// File: tb/tb_gearbox_pack.sv
// Scoreboard bench for gearbox_pack: a bit-queue model builds expected symbols on each accept
// and the monitor compares them as the DUT pops.
module tb_gearbox_pack;

   localparam int IN_W  = 16;
   localparam int OUT_W = 10;
   localparam int CAP   = IN_W + OUT_W;
   localparam int CNT_W = $clog2(CAP + 1);

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
   } sym_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic [CNT_W-1:0] level;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   bits_q[$];
   sym_t exp_q[$];

   logic             stall;
   logic [OUT_W-1:0] held_data;
   logic             held_last;

   gearbox_pack #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: handshakes are decided by the values visible at the negedge before each posedge.
   always @(negedge clk) begin
      if (rst) begin
         bits_q.delete();
         exp_q.delete();
         stall = 1'b0;
      end else begin
         sym_t s;
         if (stall && out_valid) begin
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_last", 32'(out_last), 32'(held_last));
         end
         stall     = out_valid && !out_ready;
         held_data = out_data;
         held_last = out_last;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_sym", exp_q.size(), 1);
            end else begin
               s = exp_q.pop_front();
               check("sym_data", 32'(out_data), 32'(s.data));
               check("sym_last", 32'(out_last), 32'(s.last));
            end
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < IN_W; i++) bits_q.push_back(in_data[i]);
            while (bits_q.size() >= OUT_W) begin
               for (int i = 0; i < OUT_W; i++) s.data[i] = bits_q.pop_front();
               s.last = 1'b0;
               exp_q.push_back(s);
            end
            if (in_last) begin
               if (bits_q.size() > 0) begin
                  s.data = '0;
                  for (int i = 0; bits_q.size() > 0; i++) s.data[i] = bits_q.pop_front();
                  s.last = 1'b1;
                  exp_q.push_back(s);
               end else if (exp_q.size() > 0) begin
                  exp_q[exp_q.size()-1].last = 1'b1;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IN_W-1:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", n, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = IN_W'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         idle(1);
         n++;
      end
      check("drain_done", exp_q.size(), 0);
      idle(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_level", 32'(level), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      stall     = 1'b0;
      idle(1);
      do_reset();

      // Two words, 32 bits: three symbols leave 2 bits behind.
      send(16'hFFFF, 1'b0);
      send(16'h0000, 1'b0);
      idle(5);
      check("t35_level", 32'(level), 2);
      check("t35_empty", exp_q.size(), 0);
      do_reset();

      // Five streamed words give eight full symbols and no last.
      for (int i = 0; i < 5; i++) send(IN_W'($urandom), 1'b0);
      drain();
      check("t36_level", 32'(level), 0);

      // Single-word frame.
      send(16'hABCD, 1'b1);
      check("t37_in_ready_drain", 32'(in_ready), 0);
      drain();
      check("t37_in_ready_fill", 32'(in_ready), 1);
      check("t37_level", 32'(level), 0);

      // 80-bit frame ends on a symbol boundary.
      for (int i = 0; i < 5; i++) send(IN_W'($urandom), i == 4);
      drain();
      check("t38_level", 32'(level), 0);
      check("t38_in_ready", 32'(in_ready), 1);

      // Backpressure while streaming.
      out_ready = 1'b0;
      send(16'h5A5A, 1'b0);
      fork
         send(16'h3C3C, 1'b0);
         begin
            idle(10);
            check("t39_level_cap", 32'(level <= CAP), 1);
            check("t39_in_ready", 32'(in_ready), 0);
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 3; i++) send(IN_W'($urandom), 1'b0);
      drain();
      check("t39_level", 32'(level), 0);

      // Reset in DRAIN with six bits left.
      out_ready = 1'b0;
      send(16'hABCD, 1'b1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("t40_level6", 32'(level), 6);
      check("t40_last_pending", 32'(out_last), 1);
      do_reset();
      out_ready = 1'b1;
      send(16'h1234, 1'b1);
      drain();
      check("t40_level_end", 32'(level), 0);

      check("exp_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
